// File: rtl/gemm_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gemm_tile_sequencer
// Purpose  : Walks an MxK * KxN GEMM job across an ARRAY_N x ARRAY_M
//            systolic array one output tile at a time (m-tile outer, n-tile
//            inner). Each tile runs STREAM (K cycles), DRAIN
//            (ARRAY_N+ARRAY_M-2 cycles), WRITE (a_num_rows cycles) and
//            ADVANCE (1 cycle). The job ends with a one-cycle DONE.
// Ports    : clk, reset (sync, active-low), start, [abort],
//            M/K/N dimensions, a_base/w_base/o_base buffer bases ->
//            busy, done, a_buf_on, w_buf_on, a_base_addr, w_base_addr,
//            a_num_rows, w_num_cols, operation_signal, o_ag_o_on,
//            o_base_addr. Every output comes straight from a flop.
// Options  : SEQ_ABORT_EN adds the 'abort' input, which returns any busy
//            state to IDLE on the next edge without a done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module gemm_tile_sequencer #(
  parameter int ARRAY_N    = 16,
  parameter int ARRAY_M    = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
`ifdef SEQ_ABORT_EN
  input  logic                    abort,
`endif
  input  logic [DIM_WIDTH-1:0]    M,
  input  logic [DIM_WIDTH-1:0]    K,
  input  logic [DIM_WIDTH-1:0]    N,
  input  logic [ADDR_WIDTH-1:0]   a_base,
  input  logic [ADDR_WIDTH-1:0]   w_base,
  input  logic [ADDR_WIDTH-1:0]   o_base,
  output logic                    busy,
  output logic                    done,
  output logic                    a_buf_on,
  output logic                    w_buf_on,
  output logic [ADDR_WIDTH-1:0]   a_base_addr,
  output logic [ADDR_WIDTH-1:0]   w_base_addr,
  output logic [$clog2(ARRAY_N):0] a_num_rows,
  output logic [$clog2(ARRAY_M):0] w_num_cols,
  output logic [2:0]              operation_signal,
  output logic                    o_ag_o_on,
  output logic [ADDR_WIDTH-1:0]   o_base_addr
);

  localparam int RW        = $clog2(ARRAY_N) + 1;
  localparam int CW        = $clog2(ARRAY_M) + 1;
  localparam int DRAIN_LEN = ARRAY_N + ARRAY_M - 2;

  localparam logic [2:0] OP_IDLE  = 3'b000;
  localparam logic [2:0] OP_CLEAR = 3'b001;
  localparam logic [2:0] OP_MAC   = 3'b010;
  localparam logic [2:0] OP_DRAIN = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STREAM  = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_WRITE   = 3'd3,
    ST_ADVANCE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [DIM_WIDTH-1:0]  cnt_q, cnt_d;        // cycles left in the current phase, minus one
  logic [DIM_WIDTH-1:0]  k_q, k_d;
  logic [DIM_WIDTH-1:0]  n_q, n_d;
  logic [DIM_WIDTH-1:0]  m_rem_q, m_rem_d;    // rows of A not yet covered by earlier m-tiles
  logic [DIM_WIDTH-1:0]  n_rem_q, n_rem_d;    // columns of W not yet covered in this m-row
  logic [ADDR_WIDTH-1:0] w_base_q, w_base_d;
  logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [ADDR_WIDTH-1:0] o_addr_q, o_addr_d;
  logic [RW-1:0]         rows_q, rows_d;
  logic [CW-1:0]         cols_q, cols_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  a_on_q, a_on_d;
  logic                  w_on_q, w_on_d;
  logic                  o_on_q, o_on_d;
  logic [2:0]            op_q, op_d;
  logic                  stream_first;
  logic                  last_m, last_n;
  logic                  abort_w;

`ifdef SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // A remaining count no larger than one tile means this is the last tile
  // along that dimension.
  assign last_m = (m_rem_q <= DIM_WIDTH'(ARRAY_N));
  assign last_n = (n_rem_q <= DIM_WIDTH'(ARRAY_M));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    k_d          = k_q;
    n_d          = n_q;
    m_rem_d      = m_rem_q;
    n_rem_d      = n_rem_q;
    w_base_d     = w_base_q;
    a_addr_d     = a_addr_q;
    w_addr_d     = w_addr_q;
    o_addr_d     = o_addr_q;
    stream_first = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort_w) begin
          k_d      = K;
          n_d      = N;
          w_base_d = w_base;
          m_rem_d  = M;
          n_rem_d  = N;
          a_addr_d = a_base;
          w_addr_d = w_base;
          o_addr_d = o_base;
          if (M == '0 || K == '0 || N == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d      = ST_STREAM;
            cnt_d        = K - DIM_WIDTH'(1);
            stream_first = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (cnt_q == '0) begin
          // A 1x1 array has nothing to drain; go straight to the write-out.
          if (DRAIN_LEN > 0) begin
            state_d = ST_DRAIN;
            cnt_d   = DIM_WIDTH'(DRAIN_LEN - 1);
          end else begin
            state_d = ST_WRITE;
            cnt_d   = DIM_WIDTH'(rows_q) - DIM_WIDTH'(1);
          end
        end else begin
          cnt_d = cnt_q - DIM_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_WRITE;
          cnt_d   = DIM_WIDTH'(rows_q) - DIM_WIDTH'(1);
        end else begin
          cnt_d = cnt_q - DIM_WIDTH'(1);
        end
      end
      ST_WRITE: begin
        if (cnt_q == '0) begin
          state_d = ST_ADVANCE;
        end else begin
          cnt_d = cnt_q - DIM_WIDTH'(1);
        end
      end
      ST_ADVANCE: begin
        if (last_m && last_n) begin
          state_d = ST_DONE;
        end else begin
          state_d      = ST_STREAM;
          cnt_d        = k_q - DIM_WIDTH'(1);
          stream_first = 1'b1;
          o_addr_d     = o_addr_q + ADDR_WIDTH'(ARRAY_N);
          if (last_n) begin
            // Wrap the n-tile loop and step to the next m-tile.
            n_rem_d  = n_q;
            w_addr_d = w_base_q;
            m_rem_d  = m_rem_q - DIM_WIDTH'(ARRAY_N);
            a_addr_d = a_addr_q + ADDR_WIDTH'(k_q);
          end else begin
            n_rem_d  = n_rem_q - DIM_WIDTH'(ARRAY_M);
            w_addr_d = w_addr_q + ADDR_WIDTH'(k_q);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort_w && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end

    // Edge tiles report only the rows/columns that actually exist.
    rows_d = (m_rem_d >= DIM_WIDTH'(ARRAY_N)) ? RW'(ARRAY_N) : RW'(m_rem_d);
    cols_d = (n_rem_d >= DIM_WIDTH'(ARRAY_M)) ? CW'(ARRAY_M) : CW'(n_rem_d);

    // Control outputs are decoded from the next state so they are flopped
    // together with it and line up with the state they describe.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    a_on_d = (state_d == ST_STREAM);
    w_on_d = (state_d == ST_STREAM);
    o_on_d = (state_d == ST_WRITE);
    op_d   = OP_IDLE;
    case (state_d)
      ST_STREAM: op_d = stream_first ? OP_CLEAR : OP_MAC;
      ST_DRAIN:  op_d = OP_DRAIN;
      default:   op_d = OP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      k_q      <= '0;
      n_q      <= '0;
      m_rem_q  <= '0;
      n_rem_q  <= '0;
      w_base_q <= '0;
      a_addr_q <= '0;
      w_addr_q <= '0;
      o_addr_q <= '0;
      rows_q   <= '0;
      cols_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      a_on_q   <= 1'b0;
      w_on_q   <= 1'b0;
      o_on_q   <= 1'b0;
      op_q     <= OP_IDLE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      n_q      <= n_d;
      m_rem_q  <= m_rem_d;
      n_rem_q  <= n_rem_d;
      w_base_q <= w_base_d;
      a_addr_q <= a_addr_d;
      w_addr_q <= w_addr_d;
      o_addr_q <= o_addr_d;
      rows_q   <= rows_d;
      cols_q   <= cols_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      a_on_q   <= a_on_d;
      w_on_q   <= w_on_d;
      o_on_q   <= o_on_d;
      op_q     <= op_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign a_buf_on         = a_on_q;
  assign w_buf_on         = w_on_q;
  assign o_ag_o_on        = o_on_q;
  assign operation_signal = op_q;
  assign a_base_addr      = a_addr_q;
  assign w_base_addr      = w_addr_q;
  assign o_base_addr      = o_addr_q;
  assign a_num_rows       = rows_q;
  assign w_num_cols       = cols_q;

endmodule
`default_nettype wire

// File: tb/tb_gemm_tile_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_gemm_tile_sequencer
// Purpose  : Self-checking bench for gemm_tile_sequencer (4x4 array).
//            A job-level model expands each accepted job into the expected
//            per-cycle output sequence; a monitor pops one entry per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gemm_tile_sequencer;

  localparam int AN = 4;
  localparam int AM = 4;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
`ifdef SEQ_ABORT_EN
  logic          abort;
`endif
  logic [DW-1:0] M, K, N;
  logic [AW-1:0] a_base, w_base, o_base;
  logic          busy, done, a_buf_on, w_buf_on, o_ag_o_on;
  logic [AW-1:0] a_base_addr, w_base_addr, o_base_addr;
  logic [2:0]    a_num_rows, w_num_cols, operation_signal;

  int checks   = 0;
  int failures = 0;
  int job_id   = 0;

  typedef struct {
    logic       busy, done, a_on, w_on, o_on;
    logic [2:0] op;
    logic       chk;
    logic [AW-1:0] a, w, o;
    logic [2:0] rows, cols;
    int         job, idx;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  gemm_tile_sequencer #(
    .ARRAY_N(AN), .ARRAY_M(AM), .ADDR_WIDTH(AW), .DIM_WIDTH(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
`ifdef SEQ_ABORT_EN
    .abort(abort),
`endif
    .M(M), .K(K), .N(N),
    .a_base(a_base), .w_base(w_base), .o_base(o_base),
    .busy(busy), .done(done),
    .a_buf_on(a_buf_on), .w_buf_on(w_buf_on),
    .a_base_addr(a_base_addr), .w_base_addr(w_base_addr),
    .a_num_rows(a_num_rows), .w_num_cols(w_num_cols),
    .operation_signal(operation_signal),
    .o_ag_o_on(o_ag_o_on),
    .o_base_addr(o_base_addr)
  );

  function automatic void push_rec(logic bz, logic dn, logic ab, logic wb, logic ob,
                                   logic [2:0] op, logic ck, int aa, int ww, int oo,
                                   int rr, int cc);
    exp_t e;
    e.busy = bz; e.done = dn; e.a_on = ab; e.w_on = wb; e.o_on = ob; e.op = op;
    e.chk  = ck;
    e.a    = aa[AW-1:0];
    e.w    = ww[AW-1:0];
    e.o    = oo[AW-1:0];
    e.rows = rr[2:0];
    e.cols = cc[2:0];
    e.job  = job_id;
    e.idx  = exp_q.size();
    exp_q.push_back(e);
  endfunction

  // Job-level reference: tiles, phase lengths and addresses from plain arithmetic.
  function automatic void model_job(int m, int k, int n, int ab, int wb, int ob);
    int mtc, ntc, t, rows, cols, aa, ww, oo;
    if (m == 0 || k == 0 || n == 0) begin
      push_rec(1, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
      push_rec(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
      return;
    end
    mtc = (m + AN - 1) / AN;
    ntc = (n + AM - 1) / AM;
    t   = 0;
    for (int mt = 0; mt < mtc; mt++) begin
      for (int nt = 0; nt < ntc; nt++) begin
        rows = (m - mt * AN < AN) ? m - mt * AN : AN;
        cols = (n - nt * AM < AM) ? n - nt * AM : AM;
        aa   = (ab + mt * k) % (1 << AW);
        ww   = (wb + nt * k) % (1 << AW);
        oo   = (ob + t * AN) % (1 << AW);
        for (int c = 0; c < k; c++)
          push_rec(1, 0, 1, 1, 0, (c == 0) ? 3'b001 : 3'b010, 1, aa, ww, oo, rows, cols);
        for (int c = 0; c < AN + AM - 2; c++)
          push_rec(1, 0, 0, 0, 0, 3'b100, 1, aa, ww, oo, rows, cols);
        for (int c = 0; c < rows; c++)
          push_rec(1, 0, 0, 0, 1, 3'b000, 1, aa, ww, oo, rows, cols);
        push_rec(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        t++;
      end
    end
    push_rec(1, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    push_rec(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
  endfunction

  // Monitor: one expected entry per cycle while a job is outstanding.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({busy, done, a_buf_on, w_buf_on, o_ag_o_on, operation_signal} !==
          {e.busy, e.done, e.a_on, e.w_on, e.o_on, e.op} ||
          (e.chk && ({a_base_addr, w_base_addr, o_base_addr, a_num_rows, w_num_cols} !==
                     {e.a, e.w, e.o, e.rows, e.cols}))) begin
        failures++;
        $display("FAIL job%0d_cyc%0d got bz/dn/a/w/o=%b%b%b%b%b op=%b a=%h w=%h o=%h r=%0d c=%0d expected %b%b%b%b%b op=%b a=%h w=%h o=%h r=%0d c=%0d (addr chk=%b)",
                 e.job, e.idx, busy, done, a_buf_on, w_buf_on, o_ag_o_on, operation_signal,
                 a_base_addr, w_base_addr, o_base_addr, a_num_rows, w_num_cols,
                 e.busy, e.done, e.a_on, e.w_on, e.o_on, e.op, e.a, e.w, e.o, e.rows, e.cols, e.chk);
      end
    end
  end

  task automatic check_reset_vals(input string name);
    checks++;
    if ({busy, done, a_buf_on, w_buf_on, o_ag_o_on, operation_signal,
         a_base_addr, w_base_addr, o_base_addr, a_num_rows, w_num_cols} !== '0) begin
      failures++;
      $display("FAIL %s got bz/dn/a/w/o=%b%b%b%b%b op=%b a=%h w=%h o=%h r=%0d c=%0d expected all zero",
               name, busy, done, a_buf_on, w_buf_on, o_ag_o_on, operation_signal,
               a_base_addr, w_base_addr, o_base_addr, a_num_rows, w_num_cols);
    end
  endtask

  // Called at posedge+2 with the DUT idle. With noise set, start is re-pulsed
  // with unrelated inputs while the job runs; none of it may take effect.
  task automatic run_job(input int m, input int k, input int n,
                         input int ab, input int wb, input int ob, input bit noise);
    int guard;
    job_id++;
    M = DW'(m); K = DW'(k); N = DW'(n);
    a_base = AW'(ab); w_base = AW'(wb); o_base = AW'(ob);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    model_job(m, k, n, ab, wb, ob);
    guard = 0;
    while (exp_q.size() > 0 && guard < 3000) begin
      @(posedge clk); #2;
      guard++;
      if (noise && exp_q.size() > 2 && $urandom_range(0, 4) == 0) begin
        start  = 1'b1;
        M      = DW'($urandom_range(0, 20));
        K      = DW'($urandom_range(0, 9));
        N      = DW'($urandom_range(0, 20));
        a_base = AW'($urandom);
        w_base = AW'($urandom);
        o_base = AW'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL job%0d_timeout got %0d entries pending expected 0", job_id, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int m, k, n;
    reset = 1'b0; start = 1'b0;
`ifdef SEQ_ABORT_EN
    abort = 1'b0;
`endif
    M = '0; K = '0; N = '0; a_base = '0; w_base = '0; o_base = '0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("reset_state");
    reset = 1'b1;

    run_job(4, 3, 4, 10, 20, 30, 0);          // single full tile
    run_job(6, 2, 5, 100, 200, 300, 0);       // 2x2 tiles with partial edges
    run_job(4, 0, 4, 1, 2, 3, 0);             // K=0: immediate done
    run_job(5, 1, 3, 5, 6, 7, 0);             // K=1: CLEAR only
    run_job(9, 5, 7, 1020, 1022, 1016, 0);    // address wrap
    run_job(8, 4, 8, 64, 128, 256, 1);        // start re-pulsed mid-job

    // Reset during DRAIN abandons the job; start is taken right after release.
    job_id++;
    M = DW'(4); K = DW'(3); N = DW'(4);
    a_base = AW'(11); w_base = AW'(22); o_base = AW'(33);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    model_job(4, 3, 4, 11, 22, 33);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk); #2;
    check_reset_vals("reset_mid_drain");
    reset = 1'b1;
    run_job(6, 2, 5, 40, 50, 60, 0);

    for (int j = 0; j < 30; j++) begin
      m = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      k = int'($urandom_range(0, 6));
      n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      run_job(m, k, n, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
    end

`ifdef SEQ_ABORT_EN
    // abort together with start in IDLE: no job begins
    M = DW'(4); K = DW'(1); N = DW'(4);
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_with_start got busy=%b expected 0", busy);
    end
    // abort during WRITE: K=1 -> 1 STREAM + 6 DRAIN, WRITE from cycle 8
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    checks++;
    if (o_ag_o_on !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre_write got o_ag_o_on=%b expected 1", o_ag_o_on);
    end
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    checks++;
    if ({busy, done, o_ag_o_on, operation_signal} !== 6'b0) begin
      failures++;
      $display("FAIL abort_in_write got bz/dn/o=%b%b%b op=%b expected 000 op=000",
               busy, done, o_ag_o_on, operation_signal);
    end
    @(posedge clk); #2;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL abort_no_done got bz/dn=%b%b expected 00", busy, done);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gemm_tile_sequencer.md
GEMM_TILE_SEQUENCER -- requirements
Module: gemm_tile_sequencer

Interface
REQ-001 The block SHALL have these parameters: ARRAY_N, default 16, array rows; ARRAY_M, default 16, array columns; ADDR_WIDTH, default 10, buffer address width; DIM_WIDTH, default 16, dimension width.
REQ-002 The block SHALL have these ports, in this order (name  direction  width  meaning):
- clk  in  1  single clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  job request, sampled in IDLE.
- M, K, N  in  DIM_WIDTH each  GEMM dimensions.
- a_base, w_base, o_base  in  ADDR_WIDTH each  buffer base addresses.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- a_buf_on, w_buf_on  out  1 each  A/W buffer read enables.
- a_base_addr, w_base_addr  out  ADDR_WIDTH each  current tile read bases.
- a_num_rows  out  clog2(ARRAY_N)+1  valid rows in the current tile.
- w_num_cols  out  clog2(ARRAY_M)+1  valid columns in the current tile.
- operation_signal  out  3  array opcode.
- o_ag_o_on  out  1  output buffer write enable.
- o_base_addr  out  ADDR_WIDTH  output tile base.

Function
REQ-003 Opcodes SHALL be: OP_IDLE=000, OP_CLEAR=001, OP_MAC=010, OP_DRAIN=100.
REQ-004 FSM states SHALL be IDLE, STREAM, DRAIN, WRITE, ADVANCE and DONE.
REQ-005 IDLE SHALL move on start=1 as follows: M, K and N all nonzero -> STREAM; any of them zero -> DONE.
REQ-006 M, K, N and the three base addresses SHALL be latched on the accepting edge; later input changes SHALL be ignored until the next job.
REQ-007 Tile counts SHALL be MT=ceil(M/ARRAY_N) and NT=ceil(N/ARRAY_M); the tile loop SHALL run n-tile inner, m-tile outer.
REQ-008 STREAM SHALL last exactly K cycles with a_buf_on=w_buf_on=1.
REQ-009 In STREAM, operation_signal SHALL be OP_CLEAR on the first cycle and OP_MAC on the rest; for K=1 it SHALL be OP_CLEAR only.
REQ-010 DRAIN SHALL last ARRAY_N+ARRAY_M-2 cycles with operation_signal=OP_DRAIN and both buffer enables low.
REQ-011 WRITE SHALL last a_num_rows cycles with o_ag_o_on=1.
REQ-012 ADVANCE SHALL last 1 cycle; it SHALL step the tile indices and go to STREAM, or go to DONE after the last tile.
REQ-013 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 start SHALL be ignored while busy=1.
REQ-016 a_num_rows SHALL be min(ARRAY_N, M - mt*ARRAY_N), and w_num_cols SHALL be min(ARRAY_M, N - nt*ARRAY_M), so partial edge tiles are exact.
REQ-017 a_base_addr SHALL be a_base + mt*K, and w_base_addr SHALL be w_base + nt*K.
REQ-018 o_base_addr SHALL be o_base + t*ARRAY_N, where t is the linear tile count since start.
REQ-019 All address sums SHALL be truncated modulo 2^ADDR_WIDTH (wrap, no saturation).
REQ-020 All outputs SHALL be registered, with no combinational path from an input to an output.
REQ-021 Outside the states named above, the enables SHALL be 0 and operation_signal SHALL be OP_IDLE.

Reset
REQ-022 On a clk edge with reset=0, the state SHALL go to IDLE and all counters and latched values SHALL clear.
REQ-023 After reset, busy, done, a_buf_on, w_buf_on and o_ag_o_on SHALL be 0, operation_signal SHALL be OP_IDLE, and all addresses and counts SHALL be 0.
REQ-024 Reset asserted mid-job SHALL abandon the job with no done pulse; the block SHALL accept start on the first cycle after reset is released.

Configuration
REQ-025 With SEQ_ABORT_EN defined, an input port abort (1 bit) SHALL be added after start.
REQ-026 With SEQ_ABORT_EN defined, abort=1 in any busy state SHALL give IDLE on the next edge: all enables 0, operation_signal=OP_IDLE, no done pulse.
REQ-027 With SEQ_ABORT_EN defined, abort SHALL take priority over start in the same cycle.
REQ-028 Without SEQ_ABORT_EN, the abort port SHALL be absent and jobs SHALL be stopped only by reset.

Verification (ARRAY_N=ARRAY_M=4)
REQ-029 M=4, K=3, N=4, start pulse -> STREAM 3 cycles (opcodes 001,010,010), DRAIN 6, WRITE 4, ADVANCE 1, then done at cycle 15 after acceptance.
REQ-030 M=6, K=2, N=5 -> 4 tiles with (rows,cols) = (4,4),(4,1),(2,4),(2,1); a_base_addr steps by 2 per m-tile; o_base_addr = o_base + 0,4,8,12.
REQ-031 K=0 with M=N=4 -> done one cycle after start; all buffer enables remain 0 throughout.
REQ-032 start pulsed again during STREAM with different M -> ignored; the original job completes unchanged.
REQ-033 reset=0 during DRAIN -> next cycle every output is at its reset value; a fresh start is then accepted.
REQ-034 With SEQ_ABORT_EN: abort in WRITE -> IDLE next cycle with o_ag_o_on=0 and no done; with abort and start together in IDLE -> no job starts.
